// File: rtl/text_input_pipeline.sv
// Text input stage: streams words from m1, folds ASCII upper case to lower case,
// writes each word to the same address in m2, and raises a sticky done flag.
// Pipeline: the read address is presented while in RUN, the registered SRAM read
// returns the word one cycle later, and the folded word is registered onto the
// m2 write port, so m2WE rises two cycles after the address is issued.
module text_input_pipeline #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned MAX_WORDS = 65536
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] m1ReadAddr,
  input  logic [DATA_W-1:0] m1ReadVal,
  output logic [ADDR_W-1:0] m2ReadAddr,
  input  logic [DATA_W-1:0] m2ReadVal,
  output logic [ADDR_W-1:0] m2WriteAddr,
  output logic [DATA_W-1:0] m2WriteVal,
  output logic              m2WE,
  output logic              done
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_WORDS - 1);
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   write_cnt;
  logic              s1_vld_q;
  logic [ADDR_W-1:0] s1_tag_q;

  logic              term;
  logic              issue;
  logic              last_issue;
  logic              s1_wr;
  logic [DATA_W-1:0] folded;

  // m2 read port is reserved; write_cnt is only observed hierarchically.
  logic unused_sigs;
  assign unused_sigs = ^{m2ReadVal, write_cnt};

  assign m1ReadAddr = rd_addr;
  assign m2ReadAddr = '0;

  // A valid word of all zeros marks the end of the text.
  assign term  = s1_vld_q && (m1ReadVal == '0);
  assign s1_wr = s1_vld_q && (m1ReadVal != '0);

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (term || last_issue) state_d = StDrain;
      end
      StDrain: begin
        // Any word in the m2WE register is written on this same edge.
        if (!s1_vld_q) state_d = StDone;
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM outputs: issue a read each RUN cycle unless the terminator has just arrived.
  always_comb begin
    issue      = 1'b0;
    last_issue = 1'b0;
    if (state_q == StRun && !term) begin
      issue      = 1'b1;
      last_issue = (rd_addr == LastAddr);
    end
  end

  // Byte-wise case fold: 'A'..'Z' become 'a'..'z', all other bytes pass through.
  always_comb begin
    logic [7:0] byte_v;
    byte_v = 8'h00;
    folded = m1ReadVal;
    for (int i = 0; i < NumBytes; i++) begin
      byte_v = m1ReadVal[8*i +: 8];
      if (byte_v >= 8'h41 && byte_v <= 8'h5A) begin
        folded[8*i +: 8] = byte_v + 8'h20;
      end
    end
  end

  // Read address counter; holds at the last address so it never wraps.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
    end else if (issue && !last_issue) begin
      rd_addr <= rd_addr + 1'b1;
    end
  end

  // S1 valid flag and address tag for the read in flight.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_tag_q <= '0;
    end else begin
      s1_vld_q <= issue;
      if (issue) s1_tag_q <= rd_addr;
    end
  end

  // m2 write port register; m2WE drops whenever S1 holds no writable word.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      m2WE        <= 1'b0;
      m2WriteAddr <= '0;
      m2WriteVal  <= '0;
    end else begin
      m2WE <= s1_wr;
      if (s1_wr) begin
        m2WriteAddr <= s1_tag_q;
        m2WriteVal  <= folded;
      end
    end
  end

  // Count of words committed to m2.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      write_cnt <= '0;
    end else if (m2WE) begin
      write_cnt <= write_cnt + CntOne;
    end
  end

  // Sticky completion flag.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else if (state_d == StDone) begin
      done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_text_input_pipeline.sv
// Directed bench for text_input_pipeline: one full-size instance and one with
// MAX_WORDS=8, each with behavioural SRAM models and a write log.
module tb_text_input_pipeline;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 128;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0;
  logic start_s = 1'b0;

  always #5 clock = ~clock;

  logic [AW-1:0] a_raddr, a_m2raddr, a_waddr;
  logic [DW-1:0] a_rdata, a_wval;
  logic          a_we, a_done;
  logic [AW-1:0] s_raddr, s_m2raddr, s_waddr;
  logic [DW-1:0] s_rdata, s_wval;
  logic          s_we, s_done;

  text_input_pipeline #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(65536)) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start_a),
    .m1ReadAddr  (a_raddr),
    .m1ReadVal   (a_rdata),
    .m2ReadAddr  (a_m2raddr),
    .m2ReadVal   ({DW{1'b1}}),
    .m2WriteAddr (a_waddr),
    .m2WriteVal  (a_wval),
    .m2WE        (a_we),
    .done        (a_done)
  );

  text_input_pipeline #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(8)) dut_s (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start_s),
    .m1ReadAddr  (s_raddr),
    .m1ReadVal   (s_rdata),
    .m2ReadAddr  (s_m2raddr),
    .m2ReadVal   ({DW{1'b1}}),
    .m2WriteAddr (s_waddr),
    .m2WriteVal  (s_wval),
    .m2WE        (s_we),
    .done        (s_done)
  );

  // SRAM models and write logs.
  logic [DW-1:0] m1a [0:1023];
  logic [DW-1:0] m1s [0:15];
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int unsigned   wt[$];
  logic [AW-1:0] sa[$];
  logic [DW-1:0] sd[$];
  int unsigned   cyc = 0;
  logic          s_bad = 1'b0;

  always @(posedge clock) begin
    a_rdata <= m1a[a_raddr[9:0]];
    s_rdata <= m1s[s_raddr[3:0]];
    if (a_we) begin
      wa.push_back(a_waddr);
      wd.push_back(a_wval);
      wt.push_back(cyc);
    end
    if (s_we) begin
      sa.push_back(s_waddr);
      sd.push_back(s_wval);
    end
    if (s_raddr >= 16'd8) s_bad <= 1'b1;
    cyc <= cyc + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_s = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic wait_done_a(input int budget);
    for (int i = 0; i < budget && !a_done; i++) @(negedge clock);
    check_val("done_a", a_done, 1'b1);
  endtask

  logic [DW-1:0] win  [10];
  logic [DW-1:0] wexp [10];
  int base;
  int unsigned c0;

  initial begin
    win[0] = {16{8'h41}};                                         wexp[0] = {16{8'h61}};
    win[1] = {16{8'h5A}};                                         wexp[1] = {16{8'h7A}};
    win[2] = {8'h40, 8'h41, 8'h5A, 8'h5B, 8'h7A, 8'hC1, {10{8'h20}}};
    wexp[2] = {8'h40, 8'h61, 8'h7A, 8'h5B, 8'h7A, 8'hC1, {10{8'h20}}};
    win[3] = {16{8'h61}};                                         wexp[3] = {16{8'h61}};
    win[4] = {16{8'h4D}};                                         wexp[4] = {16{8'h6D}};
    win[5] = {8{8'h00, 8'h42}};                                   wexp[5] = {8{8'h00, 8'h62}};
    win[6] = {16{8'hFF}};                                         wexp[6] = {16{8'hFF}};
    win[7] = {16{8'h60}};                                         wexp[7] = {16{8'h60}};
    win[8] = 128'h1;                                              wexp[8] = 128'h1;
    win[9] = {8{8'h41, 8'h7B}};                                   wexp[9] = {8{8'h61, 8'h7B}};
    for (int i = 0; i < 1024; i++) m1a[i] = {16{8'h2E}};
    for (int i = 0; i < 16; i++) m1s[i] = {8{8'h4B, 8'h31}};

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_m1ReadAddr", a_raddr, 0);
    check_val("rst_m2ReadAddr", a_m2raddr, 0);
    check_val("rst_m2WriteAddr", a_waddr, 0);
    check_val("rst_m2WriteVal", a_wval, 0);
    check_val("rst_m2WE", a_we, 0);
    check_val("rst_done", a_done, 0);
    check_val("rst_write_cnt", dut.write_cnt, 0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);

    // Test 1: single word then terminator.
    m1a[0] = 128'h48454C4C4F20574F524C442100000041;
    m1a[1] = '0;
    base = wa.size();
    start_a = 1'b1;
    wait_done_a(20);
    start_a = 1'b0;
    check_val("t1_nwr", wa.size() - base, 1);
    if (wa.size() > base) begin
      check_val("t1_addr", wa[base], 0);
      check_val("t1_data", wd[base], 128'h68656C6C6F20776F726C642100000061);
    end
    check_val("t1_write_cnt", dut.write_cnt, 1);

    // Test 2 (with byte boundaries of test 4 in word 2): ten words then terminator.
    apply_reset();
    for (int i = 0; i < 10; i++) m1a[i] = win[i];
    m1a[10] = '0;
    base = wa.size();
    c0 = cyc;
    start_a = 1'b1;
    wait_done_a(40);
    check_val("t2_nwr", wa.size() - base, 10);
    if (wa.size() >= base + 10) begin
      for (int i = 0; i < 10; i++) begin
        check_val($sformatf("t2_addr%0d", i), wa[base+i], i);
        check_val($sformatf("t2_data%0d", i), wd[base+i], wexp[i]);
        check_val($sformatf("t2_cycle%0d", i), wt[base+i], c0 + 3 + i);
      end
    end
    check_val("t2_write_cnt", dut.write_cnt, 10);
    repeat (5) @(negedge clock);
    check_val("t2_done_sticky", a_done, 1);
    check_val("t2_no_rerun", wa.size() - base, 10);
    start_a = 1'b0;

    // Test 3: empty text.
    apply_reset();
    m1a[0] = '0;
    base = wa.size();
    start_a = 1'b1;
    for (int i = 0; i < 4 && !a_done; i++) @(negedge clock);
    check_val("t3_done", a_done, 1);
    start_a = 1'b0;
    repeat (3) @(negedge clock);
    check_val("t3_nwr", wa.size() - base, 0);
    check_val("t3_write_cnt", dut.write_cnt, 0);

    // Test 5: reset after the third write, then restart.
    apply_reset();
    m1a[0] = win[0];
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    base = wa.size();
    for (int i = 0; i < 30 && dut.write_cnt != 3; i++) @(negedge clock);
    check_val("t5_cnt3", dut.write_cnt, 3);
    rst_n = 1'b0;
    #1;
    check_val("t5_m2WE", a_we, 0);
    check_val("t5_m2WriteAddr", a_waddr, 0);
    check_val("t5_m2WriteVal", a_wval, 0);
    check_val("t5_m1ReadAddr", a_raddr, 0);
    check_val("t5_write_cnt", dut.write_cnt, 0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    check_val("t5_no_extra", wa.size() - base, 3);
    @(negedge clock);
    base = wa.size();
    start_a = 1'b1;
    wait_done_a(40);
    start_a = 1'b0;
    check_val("t5_nwr", wa.size() - base, 10);
    if (wa.size() > base) check_val("t5_first_addr", wa[base], 0);
    check_val("t5_write_cnt_end", dut.write_cnt, 10);

    // Test 6: MAX_WORDS=8 with no terminator.
    base = sa.size();
    start_s = 1'b1;
    for (int i = 0; i < 40 && !s_done; i++) @(negedge clock);
    start_s = 1'b0;
    check_val("t6_done", s_done, 1);
    check_val("t6_nwr", sa.size() - base, 8);
    if (sa.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) check_val($sformatf("t6_addr%0d", i), sa[base+i], i);
      check_val("t6_data0", sd[base], {8{8'h6B, 8'h31}});
    end
    check_val("t6_no_addr8", s_bad, 0);
    check_val("t6_write_cnt", dut_s.write_cnt, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
